// File: rtl/pipe_reg_stage_pkg.sv
// Shared constants for the generic pipeline register chain.
// PIPE_REG_SKID_EN adds a skid entry, which widens the occupancy count.
package pipe_pkg;

  localparam int unsigned CTRL_REGWRITE = 0;
  localparam int unsigned CTRL_MEMTOREG = 1;
  localparam int unsigned CTRL_MEMREAD  = 2;
  localparam int unsigned CTRL_MEMWRITE = 3;

  localparam int unsigned DEF_DATA_W = 64;
  localparam int unsigned DEF_CTRL_W = 4;
  localparam int unsigned DEF_TAG_W  = 5;
  localparam int unsigned MAX_DEPTH  = 4;

  function automatic int unsigned occ_width(input int unsigned depth);
`ifdef PIPE_REG_SKID_EN
    return $clog2(depth + 2);
`else
    return $clog2(depth + 1);
`endif
  endfunction

endpackage

// File: rtl/pipe_reg_stage_if.sv
// Upstream/downstream bundle of pipe_reg_stage; port names kept from the flat version.
// occ_o width follows PIPE_REG_SKID_EN through pipe_pkg::occ_width.
interface pipe_reg_stage_if import pipe_pkg::*; #(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned CTRL_W = DEF_CTRL_W,
  parameter int unsigned TAG_W  = DEF_TAG_W,
  parameter int unsigned DEPTH  = 1
);
  localparam int unsigned OCC_W = occ_width(DEPTH);

  logic              valid_i;
  logic              ready_o;
  logic [DATA_W-1:0] data_i;
  logic [CTRL_W-1:0] ctrl_i;
  logic [TAG_W-1:0]  tag_i;
  logic              valid_o;
  logic              ready_i;
  logic [DATA_W-1:0] data_o;
  logic [CTRL_W-1:0] ctrl_o;
  logic [TAG_W-1:0]  tag_o;
  logic [OCC_W-1:0]  occ_o;

  modport master (
    output valid_i, data_i, ctrl_i, tag_i, ready_i,
    input  ready_o, valid_o, data_o, ctrl_o, tag_o, occ_o
  );

  modport slave (
    input  valid_i, data_i, ctrl_i, tag_i, ready_i,
    output ready_o, valid_o, data_o, ctrl_o, tag_o, occ_o
  );
endinterface

// File: rtl/pipe_reg_cell.sv
// One pipeline stage: valid, ctrl, data and tag with load/clear.
// ctrl is forced to zero whenever the stage is invalid; data/tag keep their old value on bubbles.
module pipe_reg_cell #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CTRL_W = 4,
  parameter int unsigned TAG_W  = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic              valid_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [TAG_W-1:0]  tag_i,
  output logic              valid_o,
  output logic              valid_d_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [TAG_W-1:0]  tag_o
);
  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [TAG_W-1:0]  tag_q, tag_d;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    tag_d   = tag_q;
    if (clr_i) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (load_i) begin
      valid_d = valid_i;
      ctrl_d  = valid_i ? ctrl_i : '0;
      if (valid_i) begin
        data_d = data_i;
        tag_d  = tag_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
    end
  end

  assign valid_o   = valid_q;
  assign valid_d_o = valid_d;
  assign ctrl_o    = ctrl_q;
  assign data_o    = data_q;
  assign tag_o     = tag_q;
endmodule

// File: rtl/pipe_reg_stage.sv
// Generic DEPTH-stage pipeline register chain with valid/ready, stall and flush.
// Define PIPE_REG_SKID_EN for a 1-entry skid buffer in front of stage 0 (registered ready_o).
module pipe_reg_stage import pipe_pkg::*; #(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned CTRL_W = DEF_CTRL_W,
  parameter int unsigned TAG_W  = DEF_TAG_W,
  parameter int unsigned DEPTH  = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic stall_i,
  input  logic flush_i,
  pipe_reg_stage_if.slave bus
);
  localparam int unsigned OCC_W = occ_width(DEPTH);

  if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_depth
    $error("pipe_reg_stage: DEPTH out of range");
  end

  logic [DEPTH-1:0]  v_q, v_d, adv, load, in_v;
  logic [CTRL_W-1:0] ctrl_q  [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];
  logic [TAG_W-1:0]  tag_q   [DEPTH];
  logic [CTRL_W-1:0] in_ctrl [DEPTH];
  logic [DATA_W-1:0] in_data [DEPTH];
  logic [TAG_W-1:0]  in_tag  [DEPTH];

  logic              s0_v;
  logic [CTRL_W-1:0] s0_ctrl;
  logic [DATA_W-1:0] s0_data;
  logic [TAG_W-1:0]  s0_tag;
  logic [OCC_W-1:0]  occ_q, occ_d;

  // Advance is resolved from the output side back towards stage 0.
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = v_q[DEPTH-1] & bus.ready_i;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      adv[DEPTH-1-i] = v_q[DEPTH-1-i] & (~v_q[DEPTH-i] | adv[DEPTH-i]);
    end
    for (int unsigned k = 0; k < DEPTH; k++) begin
      load[k] = ~stall_i & (~v_q[k] | adv[k]);
    end
  end

  always_comb begin
    in_v       = '0;
    in_v[0]    = s0_v;
    in_ctrl[0] = s0_ctrl;
    in_data[0] = s0_data;
    in_tag[0]  = s0_tag;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      in_v[k]    = v_q[k-1] & adv[k-1];
      in_ctrl[k] = ctrl_q[k-1];
      in_data[k] = data_q[k-1];
      in_tag[k]  = tag_q[k-1];
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    pipe_reg_cell #(
      .DATA_W(DATA_W),
      .CTRL_W(CTRL_W),
      .TAG_W (TAG_W)
    ) u_cell (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clr_i    (flush_i),
      .load_i   (load[k]),
      .valid_i  (in_v[k]),
      .ctrl_i   (in_ctrl[k]),
      .data_i   (in_data[k]),
      .tag_i    (in_tag[k]),
      .valid_o  (v_q[k]),
      .valid_d_o(v_d[k]),
      .ctrl_o   (ctrl_q[k]),
      .data_o   (data_q[k]),
      .tag_o    (tag_q[k])
    );
  end

`ifdef PIPE_REG_SKID_EN
  logic              skid_v_q, skid_v_d, rdy_q, rdy_d, accept;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [TAG_W-1:0]  skid_tag_q, skid_tag_d;

  assign accept = bus.valid_i & rdy_q;

  // A held skid entry always feeds stage 0 first; ready_o is low while it is held.
  always_comb begin
    skid_v_d    = skid_v_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    skid_tag_d  = skid_tag_q;
    s0_v        = skid_v_q | accept;
    s0_ctrl     = skid_v_q ? skid_ctrl_q : bus.ctrl_i;
    s0_data     = skid_v_q ? skid_data_q : bus.data_i;
    s0_tag      = skid_v_q ? skid_tag_q  : bus.tag_i;
    if (flush_i) begin
      skid_v_d = 1'b0;
    end else if (skid_v_q) begin
      if (load[0]) skid_v_d = 1'b0;
    end else if (accept && !load[0]) begin
      skid_v_d    = 1'b1;
      skid_ctrl_d = bus.ctrl_i;
      skid_data_d = bus.data_i;
      skid_tag_d  = bus.tag_i;
    end
    rdy_d = ~skid_v_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      skid_v_q    <= 1'b0;
      rdy_q       <= 1'b0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_tag_q  <= '0;
    end else begin
      skid_v_q    <= skid_v_d;
      rdy_q       <= rdy_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_tag_q  <= skid_tag_d;
    end
  end

  assign bus.ready_o = rdy_q;
`else
  assign s0_v        = bus.valid_i;
  assign s0_ctrl     = bus.ctrl_i;
  assign s0_data     = bus.data_i;
  assign s0_tag      = bus.tag_i;
  assign bus.ready_o = ~stall_i & ~flush_i & (~v_q[0] | adv[0]);
`endif

  always_comb begin
    occ_d = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      occ_d = occ_d + OCC_W'(v_d[k]);
    end
`ifdef PIPE_REG_SKID_EN
    occ_d = occ_d + OCC_W'(skid_v_d);
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) occ_q <= '0;
    else       occ_q <= occ_d;
  end

  assign bus.valid_o = v_q[DEPTH-1];
  assign bus.ctrl_o  = ctrl_q[DEPTH-1];
  assign bus.data_o  = data_q[DEPTH-1];
  assign bus.tag_o   = tag_q[DEPTH-1];
  assign bus.occ_o   = occ_q;
endmodule

// File: tb/tb_pipe_reg_stage.sv
// Scoreboard bench for pipe_reg_stage (DEPTH=3); also builds with PIPE_REG_SKID_EN.
module tb_pipe_reg_stage;
  import pipe_pkg::*;

  localparam int unsigned D  = 3;
  localparam int unsigned DW = 64;
  localparam int unsigned CW = 4;
  localparam int unsigned TW = 5;
`ifdef PIPE_REG_SKID_EN
  localparam int unsigned SKID_N = 1;
`else
  localparam int unsigned SKID_N = 0;
`endif

  typedef logic [DW+CW+TW-1:0] ent_t;

  logic clk = 1'b0;
  logic rst, stall, flush, acc;
  always #5 clk = ~clk;

  pipe_reg_stage_if #(.DATA_W(DW), .CTRL_W(CW), .TAG_W(TW), .DEPTH(D)) bus_if ();

  pipe_reg_stage #(.DATA_W(DW), .CTRL_W(CW), .TAG_W(TW), .DEPTH(D)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .stall_i(stall),
    .flush_i(flush),
    .bus    (bus_if)
  );

  ent_t            sb[$];
  logic [D-1:0]    mv;
  int unsigned     n_chk = 0;
  int unsigned     n_pass = 0;
  int unsigned     occ_peak, nacc;
  logic [DW+CW+TW:0] snap;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [D-1:0] m_adv(input logic [D-1:0] v, input logic rdy);
    logic [D-1:0] a;
    a = '0;
    a[D-1] = v[D-1] & rdy;
    for (int i = int'(D) - 2; i >= 0; i--) a[i] = v[i] & (~v[i+1] | a[i+1]);
    return a;
  endfunction

  // One clock: drive, check pre-edge handshake, advance the model, check post-edge state.
  task automatic step(input logic v, input logic [7:0] b, input logic rdy,
                      input logic stl, input logic fl);
    logic [D-1:0] a, nv;
    ent_t e;
    e = {{8{b}}, b[3:0], b[4:0]};
    {bus_if.data_i, bus_if.ctrl_i, bus_if.tag_i} = e;
    bus_if.valid_i = v;
    bus_if.ready_i = rdy;
    stall = stl;
    flush = fl;
    #1;
    a = m_adv(mv, rdy);
    acc = 1'b0;
    if (!rst) begin
`ifdef PIPE_REG_SKID_EN
      begin
        logic r0;
        r0 = bus_if.ready_o;
        bus_if.ready_i = ~rdy;
        #1;
        check("skid_ready_stable", 128'(bus_if.ready_o), 128'(r0));
        bus_if.ready_i = rdy;
        #1;
        acc = v & r0 & ~fl;
      end
`else
      begin
        logic exp_rdy;
        exp_rdy = ~stl & ~fl & (~mv[0] | a[0]);
        check("ready_o", 128'(bus_if.ready_o), 128'(exp_rdy));
        acc = v & exp_rdy;
      end
`endif
      if (fl) sb.delete();
      else if (bus_if.valid_o && rdy && !stl) begin
        check("sb_avail", 128'(sb.size() != 0), 128'(1));
        if (sb.size() != 0)
          check("payload", 128'({bus_if.data_o, bus_if.ctrl_o, bus_if.tag_o}), 128'(sb.pop_front()));
      end
      if (acc) sb.push_back(e);
    end
    nv = '0;
    if (!rst && !fl) begin
      nv = mv;
      if (!stl) begin
        for (int k = 0; k < int'(D); k++) begin
          if (!mv[k] || a[k]) begin
            if (k == 0) nv[k] = v;
            else        nv[k] = mv[k-1] & a[k-1];
          end
        end
      end
    end
    @(posedge clk);
    #1;
    mv = nv;
`ifndef PIPE_REG_SKID_EN
    check("valid_o", 128'(bus_if.valid_o), 128'(mv[D-1]));
    check("occ_o", 128'(bus_if.occ_o), 128'($countones(mv)));
    if (!mv[D-1]) check("ctrl_o_bubble", 128'(bus_if.ctrl_o), 128'(0));
`else
    if (rst) begin
      check("rst_valid_o", 128'(bus_if.valid_o), 128'(0));
      check("rst_occ_o", 128'(bus_if.occ_o), 128'(0));
      check("rst_ctrl_o", 128'(bus_if.ctrl_o), 128'(0));
      check("rst_ready_o", 128'(bus_if.ready_o), 128'(0));
    end
`endif
    if (rst) check("rst_data_tag", 128'({bus_if.data_o, bus_if.tag_o}), 128'(0));
    if (int'(bus_if.occ_o) > int'(occ_peak)) occ_peak = int'(bus_if.occ_o);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; mv = '0; occ_peak = 0; nacc = 0;
    bus_if.valid_i = 1'b0; bus_if.ready_i = 1'b0;
    bus_if.data_i = '0; bus_if.ctrl_i = '0; bus_if.tag_i = '0;

    // Reset with a live, all-ones-ctrl input
    repeat (2) step(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;

    // Streaming
    occ_peak = 0;
    step(1'b1, 8'h11, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
    check("stream_latency_valid", 128'(bus_if.valid_o), 128'(1));
    check("stream_first_data", 128'(bus_if.data_o), 128'(64'h1111111111111111));
    repeat (4) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("occ_peak", 128'(occ_peak), 128'(D));

    // Backpressure
    nacc = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'(8'h40 + nacc), 1'b0, 1'b0, 1'b0);
      nacc += int'(acc);
    end
    check("bp_accepted", 128'(nacc), 128'(D + SKID_N));
    check("bp_occ", 128'(bus_if.occ_o), 128'(D + SKID_N));
    step(1'b1, 8'(8'h40 + nacc), 1'b1, 1'b0, 1'b0);
    repeat (6) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Stall mid-stream
    step(1'b1, 8'hA3, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'hA4, 1'b1, 1'b0, 1'b0);
    snap = {bus_if.valid_o, bus_if.data_o, bus_if.ctrl_o, bus_if.tag_o};
    repeat (2) begin
      step(1'b1, 8'hA5, 1'b1, 1'b1, 1'b0);
      check("stall_hold", 128'({bus_if.valid_o, bus_if.data_o, bus_if.ctrl_o, bus_if.tag_o}), 128'(snap));
    end
    begin
      int unsigned tries;
      tries = 0;
      acc = 1'b0;
      while (!acc && tries < 10) begin
        step(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
        tries++;
      end
      check("stall_resume_accept", 128'(acc), 128'(1));
    end
    step(1'b1, 8'hA6, 1'b1, 1'b0, 1'b0);
    repeat (6) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Flush together with stall
    step(1'b1, 8'hB1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hB2, 1'b0, 1'b0, 1'b0);
    check("occ_pre_flush", 128'(bus_if.occ_o), 128'(2));
    step(1'b1, 8'hEE, 1'b0, 1'b1, 1'b1);
    check("flush_valid_o", 128'(bus_if.valid_o), 128'(0));
    check("flush_ctrl_o", 128'(bus_if.ctrl_o), 128'(0));
    check("flush_occ_o", 128'(bus_if.occ_o), 128'(0));
    repeat (4) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("flush_no_output", 128'(bus_if.valid_o), 128'(0));

`ifdef PIPE_REG_SKID_EN
    // Skid: toggling ready_i, nothing dropped, order kept
    nacc = 0;
    for (int i = 0; i < 40 && nacc < 12; i++) begin
      step(1'b1, 8'(8'hC0 + nacc), i[0], 1'b0, 1'b0);
      nacc += int'(acc);
    end
    check("skid_sent", 128'(nacc), 128'(12));
    repeat (8) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
`endif

    check("sb_drained", 128'(sb.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pipe_reg_stage.md
Name: pipe_reg_stage

Overview:
- Parametrised pipeline register chain that replaces the fixed per-boundary registers (ID/EX, EX/MEM, MEM/WB) with one generic block.
- Carries a data bundle and a control bundle through DEPTH register stages.
- Each stage has a valid bit, with a valid/ready handshake, global stall (hold) and flush (bubble insert).
- Control bits of an invalid stage are always zero, so bubbles never cause register-file or memory writes.

Parameters:
- DATA_W, 64: width of data bundle (e.g. ALU result + store data).
- CTRL_W, 4: width of control bundle (e.g. RegWrite, MemtoReg, MemRead, MemWrite).
- TAG_W, 5: width of destination-register tag carried alongside.
- DEPTH, 1: number of register stages, legal range 1..4.

Ports:
- clk_i  in  1  clock, all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- stall_i  in  1  freeze all stages (hold contents).
- flush_i  in  1  invalidate all stages.
- valid_i  in  1  upstream entry valid.
- ready_o  out  1  block can accept an entry this cycle.
- data_i  in  DATA_W  upstream data.
- ctrl_i  in  CTRL_W  upstream control.
- tag_i  in  TAG_W  upstream destination tag.
- valid_o  out  1  last stage holds a valid entry.
- ready_i  in  1  downstream accepts last-stage entry.
- data_o  out  DATA_W  last-stage data.
- ctrl_o  out  CTRL_W  last-stage control, zero when valid_o=0.
- tag_o  out  TAG_W  last-stage tag.
- occ_o  out  $clog2(DEPTH+1)  count of valid stages.

Behaviour:
- Reset (rst_i=1 at a clock edge): all stage valids, ctrl, tag and data clear to 0. Therefore valid_o=0, ctrl_o=0, data_o=0, tag_o=0, occ_o=0. rst_i has priority over flush_i and stall_i.
- Stage index: 0 is the input side, DEPTH-1 drives the outputs.
- Advance rule: adv[DEPTH-1] = v[DEPTH-1] & ready_i. For k<DEPTH-1, adv[k] = v[k] & (~v[k+1] | adv[k+1]).
- Stage k loads when ~stall_i & (~v[k] | adv[k]).
  - Loaded from stage k-1, or from the inputs for k=0.
  - Valid loaded = upstream valid & upstream advancing, or valid_i for k=0.
- Bubble load (incoming valid=0): v=0 and ctrl=0; data and tag hold their old values.
- Emptied stage (adv[k]=1 with nothing entering): becomes v=0, ctrl=0.
- ready_o = ~stall_i & ~flush_i & (~v[0] | adv[0]). Combinational.
- Accept: valid_i & ready_o at the edge.
- Latency: an accepted entry reaches valid_o exactly DEPTH cycles later if never blocked. Throughput is 1 entry/cycle.
- stall_i=1: no stage changes, ready_o=0. valid_o and ctrl_o are held; ready_i is ignored, so no handoff is counted.
- flush_i=1 (no reset): next edge sets all v=0 and ctrl=0; data and tag hold. Flush beats stall. An input offered in the flush cycle is dropped (ready_o=0).
- Full chain with ready_i=0: all stages hold and ready_o=0.
- Full chain with ready_i=1: shifts by one while accepting simultaneously, so ready_o=1.
- occ_o = popcount of stage valids, registered alongside them.
- valid_o, ctrl_o, data_o and tag_o come directly from the last-stage flops (no combinational path from inputs).

Optional Feature:
- Macro PIPE_REG_SKID_EN.
- When defined: a 1-entry skid buffer (valid, data, ctrl, tag) sits before stage 0.
  - ready_o becomes a registered signal: ready_o = ~skid_valid. It no longer depends on ready_i, stall_i or flush_i combinationally.
  - An entry accepted while stage 0 cannot load goes to the skid buffer. The skid buffer drains into stage 0 with priority over new input.
  - flush_i clears skid_valid. Reset clears skid_valid and sets ready_o=0 during reset, 1 after.
  - occ_o counts the skid entry and widens to $clog2(DEPTH+2).
- When undefined: the combinational ready_o defined above; no skid storage.

Decomposition:
- Shared package pipe_pkg holds:
  - ctrl bit index constants (CTRL_REGWRITE=0, CTRL_MEMTOREG=1, CTRL_MEMREAD=2, CTRL_MEMWRITE=3);
  - the default DATA_W/TAG_W constants;
  - a max DEPTH constant (4).
- One sub-module: pipe_reg_cell.
  - Contents: single stage holding valid, ctrl, data and tag, with load/clear inputs.
  - The top generates DEPTH instances and the advance chain.

Test Plan:
- Reset: hold rst_i=1 two cycles with valid_i=1 and ctrl_i=4'hF, then release. valid_o=0, ctrl_o=0, occ_o=0 during reset; first accept appears at valid_o DEPTH cycles after release.
- Streaming: DEPTH=3, ready_i=1, send data 0x11,0x22,0x33 on consecutive cycles. valid_o rises on cycle 3 and outputs 0x11,0x22,0x33 back-to-back; occ_o peaks at 3.
- Backpressure: DEPTH=2, ready_i=0, offer 3 entries. First 2 accepted; ready_o=0 afterwards, occ_o=2. Raise ready_i: entry 1 leaves and ready_o=1 in the same cycle.
- Stall: mid-stream assert stall_i for 2 cycles. All outputs unchanged, ready_o=0. Resume with no loss or duplication of entry 0xA5.
- Flush with simultaneous stall: occ_o=2, set flush_i=1 and stall_i=1 together. Next cycle valid_o=0, ctrl_o=0, occ_o=0; the entry offered that cycle is not accepted.
- Skid (PIPE_REG_SKID_EN): DEPTH=1, ready_i toggling 1/0. No entry is dropped; ready_o never changes combinationally with ready_i; order is preserved.
